// File: rtl/rv32i_types.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rv32i_types: shared fetch-queue types, opcodes and the BTFN predictor helper.
// Revision: 1.0
// ----------------------------------------------------------------------------
package rv32i_types;

  localparam logic [6:0] op_b_jal = 7'b1101111;
  localparam logic [6:0] op_b_br  = 7'b1100011;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  // Returns {taken, next_pc}: JAL always taken, backward conditional branches taken.
  function automatic logic [32:0] btfn_predict(input logic [31:0] inst, input logic [31:0] pc);
    logic [31:0] j_imm;
    logic [31:0] b_imm;
    j_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    b_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    if (inst[6:0] == op_b_jal) return {1'b1, pc + j_imm};
    if ((inst[6:0] == op_b_br) && inst[31]) return {1'b1, pc + b_imm};
    return {1'b0, pc + 32'd4};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_fifo: DEPTH-entry ring buffer of fetch entries with push, pop and flush.
// Revision: 1.0
// ----------------------------------------------------------------------------
module fetch_fifo
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [PTR_W:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/fetch_queue_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_queue_stage: one-outstanding imem fetcher feeding a DEPTH-entry decode queue.
// Optional macro FETCH_BTFN_EN: backward-taken/forward-not-taken next-PC prediction.
// Revision: 1.0
// ----------------------------------------------------------------------------
module fetch_queue_stage
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  parameter int unsigned ORDER_W  = 64
) (
  input  logic               clk,
  input  logic               rst,
  output logic [31:0]        imem_addr,
  output logic [3:0]         imem_rmask,
  input  logic               imem_resp,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_en,
  input  logic [31:0]        redirect_pc,
  input  logic [ORDER_W-1:0] redirect_order,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_inst,
  output logic [31:0]        out_pc,
  output logic               out_pred_taken,
  output logic [31:0]        out_pred_pc,
  output logic [ORDER_W-1:0] out_order
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t       state;
  fetch_state_t       state_n;
  logic [31:0]        pc;
  logic [31:0]        pc_n;
  logic [31:0]        fetch_addr;
  logic [ORDER_W-1:0] order;
  logic [32:0]        pred;
  logic               push;
  logic               pop;
  logic               launch;
  logic               full;
  logic               empty;
  logic [CNT_W-1:0]   count;
  fetch_entry_t       push_entry;
  fetch_entry_t       head;

`ifdef FETCH_BTFN_EN
  assign pred = btfn_predict(imem_rdata, pc);
`else
  assign pred = {1'b0, pc + 32'd4};
`endif

  assign push_entry = '{inst: imem_rdata, pc: pc, pred_taken: pred[32], pred_pc: pred[31:0]};

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    push       = 1'b0;
    launch     = 1'b0;
    fetch_addr = pc;
    case (state)
      S_IDLE: begin
        if (redirect_en) begin
          pc_n = redirect_pc;
        end else if (!full) begin
          launch  = 1'b1;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_en) begin
          pc_n    = redirect_pc;
          state_n = imem_resp ? S_IDLE : S_DRAIN;
        end else if (imem_resp) begin
          push = 1'b1;
          pc_n = pred[31:0];
          // Chain the next request only if the queue still has room after this push.
          if (count < CNT_W'(DEPTH - 1)) begin
            launch     = 1'b1;
            fetch_addr = pred[31:0];
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (redirect_en) pc_n = redirect_pc;
        if (imem_resp)   state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign pop        = !empty && out_ready && !redirect_en;
  assign imem_rmask = (launch && !rst) ? 4'b1111 : 4'b0000;
  assign imem_addr  = fetch_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
      order <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (redirect_en) order <= redirect_order;
      else if (pop)    order <= order + 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect_en),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign out_valid      = !empty;
  assign out_inst       = head.inst;
  assign out_pc         = head.pc;
  assign out_pred_taken = head.pred_taken;
  assign out_pred_pc    = head.pred_pc;
  assign out_order      = order;

endmodule
`default_nettype wire

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
Parametrised successor to the pipelined core's fetch stage, sitting between imem and decode. It issues one-word fetches with one request outstanding and can issue back-to-back, buffering up to DEPTH instructions. Stale in-flight responses are squashed with a drain state after a redirect. Decode consumes instructions over a valid/ready handshake. RVFI order is generated internally and restored on redirect.

Parameters:
DEPTH, 8, queue entries; power of two, >=2
RESET_PC, 32'h1eceb000, first fetch address after reset
ORDER_W, 64, width of out_order

Ports:
clk  in  1  clock
rst  in  1  reset
imem_addr  out  32  fetch address, meaningful only when imem_rmask != 0
imem_rmask  out  4  4'b1111 for exactly one cycle per request, else 0
imem_resp  in  1  response for the single outstanding request
imem_rdata  in  32  instruction word, valid with imem_resp
redirect_en  in  1  single-cycle flush/redirect from execute
redirect_pc  in  32  new fetch PC
redirect_order  in  ORDER_W  order value for the next instruction handed to decode
out_valid  out  1  queue non-empty
out_ready  in  1  decode accepts the head entry
out_inst  out  32  head instruction
out_pc  out  32  head PC
out_pred_taken  out  1  head prediction
out_pred_pc  out  32  head predicted next PC
out_order  out  ORDER_W  RVFI order of head

Behaviour:
- Interface: single clock clk; reset rst is synchronous, active-high.
- Reset: state S_IDLE, pc=RESET_PC, count=0, order=0, out_valid=0, imem_rmask=0 during reset.
- FSM states: S_IDLE (nothing outstanding), S_WAIT (live request outstanding), S_DRAIN (stale request outstanding).
- S_IDLE:
  - If count<DEPTH and no redirect: rmask=1111, addr=pc, go to S_WAIT.
  - Otherwise stay in S_IDLE.
  - imem_resp is ignored in S_IDLE and S_IDLE-after-reset.
- S_WAIT, on imem_resp without redirect:
  - Push {rdata, pc, pred}.
  - Advance pc to next_pc (pc+4, or the predicted target under the optional feature).
  - If count_after_push<DEPTH, launch the next request in the same cycle at next_pc (addr combinational) and stay in S_WAIT; this gives 1 instr/cycle.
  - Otherwise go to S_IDLE.
- Space guarantee: a request launches only when a slot is free, and count cannot increase while the request is outstanding, so a push never overflows.
- Decode handshake:
  - Pop when out_valid && out_ready && !redirect_en; order increments by 1 on each pop.
  - Push and pop in the same cycle leave count unchanged.
  - Outputs are combinational from the head entry; out_order is the order register.
- Redirect (any state, highest priority):
  - Flush the queue (count=0, pointers reset); pop is ignored.
  - pc<=redirect_pc, order<=redirect_order, no request launched that cycle.
  - S_WAIT with no imem_resp that cycle -> S_DRAIN.
  - S_WAIT with imem_resp that cycle -> response discarded, go to S_IDLE.
  - In S_IDLE -> stay in S_IDLE. In S_DRAIN -> stay in S_DRAIN with pc updated.
- S_DRAIN: rmask=0; on imem_resp, discard the data and go to S_IDLE.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally; full/empty are derived from count (log2(DEPTH)+1 bits).
- Reset mid-operation returns to the reset values; any later response is ignored because the block is in S_IDLE.

Optional Feature:
Macro FETCH_BTFN_EN.
- Enabled: the enqueued word is pre-decoded. JAL is predicted taken with target pc+J-imm. A branch (opcode 1100011) with negative B-imm is predicted taken with target pc+B-imm. On a taken prediction, out_pred_taken=1, out_pred_pc=target, and the next fetch goes to the target. Everything else is not taken.
- Disabled: out_pred_taken=0, out_pred_pc=pc+4, sequential fetch only.

Decomposition:
- rv32i_types package: fetch_entry_t {inst, pc, pred_taken, pred_pc}; fetch_state_t enum {S_IDLE, S_WAIT, S_DRAIN}; opcode constants (op_b_jal, op_b_br) used by the predictor.
- One sub-module, fetch_fifo: parametrised DEPTH ring buffer of fetch_entry_t with push, pop and flush, exposing count, full and empty.

Test Plan:
- Reset release, out_ready=1 -> cycle 1: rmask=1111, addr=0x1eceb000; out_valid=0 until the first response.
- 1-cycle-latency memory, out_ready=1 -> addrs 0x1eceb000, 04, 08... issued back-to-back; out_order 0,1,2 matching those PCs.
- out_ready=0, DEPTH=8 -> after 8 pushes: rmask=0, out_valid=1. One-cycle out_ready -> one pop, and the next cycle launches a fetch at 0x1eceb020.
- Redirect to 0x1eceb100 while a request is outstanding; response 0xdeadbeef arrives 3 cycles later -> discarded, queue empty, next request addr=0x1eceb100.
- redirect_en, imem_resp and an out_ready pop in the same cycle (redirect_order=42) -> response dropped, no pop, count=0, the next popped entry has out_order=42.
- FETCH_BTFN_EN: beq imm=-8 at 0x1eceb010 -> out_pred_taken=1, out_pred_pc=0x1eceb008, next imem_addr=0x1eceb008. Without the macro -> pred 0, next addr 0x1eceb014.
